// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared widths and FSM state encodings for the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;

    typedef enum logic [1:0] {
        ICACHE_IDLE  = 2'd0,
        ICACHE_RESP  = 2'd1,
        ICACHE_FILL  = 2'd2,
        ICACHE_DELIV = 2'd3
    } icache_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_array.sv
// ============================================================================
// Module      : icache_array
// Description : Valid/tag/data storage for the direct-mapped icache; one
//               asynchronous read port, one write port, bulk valid clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_array #(
    parameter int IDX_W = 6,
    parameter int OFS_W = 2,
    parameter int TAG_W = 22
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFS_W-1:0] rd_word,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFS_W-1:0] wr_word,
    input  logic [31:0]      wr_data,
    input  logic             wr_set_valid,
    input  logic [TAG_W-1:0] wr_tag
);

    localparam int c_LINES = 1 << IDX_W;
    localparam int c_WORDS = 1 << OFS_W;

    logic [c_LINES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag  [c_LINES];
    logic [31:0]        r_data [c_LINES][c_WORDS];

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (we && wr_set_valid) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    // Tag is only written with the final word so a partial line never matches.
    always_ff @(posedge clk) begin
        if (we) begin
            r_data[wr_idx][wr_word] <= wr_data;
            if (wr_set_valid) begin
                r_tag[wr_idx] <= wr_tag;
            end
        end
    end

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx][rd_word];

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache with word-by-word line refill.
//               Optional hit/miss counters when ICACHE_STAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache
    import icache_pkg::*;
#(
    parameter int LINE_CNT   = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  flush,
    output logic                  inst_rdy,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_data
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int IDX_W = $clog2(LINE_CNT);
    localparam int OFS_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFS_W - IDX_W;

    icache_state_e    r_state, w_state_nxt;
    logic [TAG_W-1:0] r_tag;
    logic [IDX_W-1:0] r_idx;
    logic [OFS_W-1:0] r_word;
    logic [OFS_W-1:0] r_k;
    logic             r_abort;
    logic [INST_WIDTH-1:0] r_inst_out;

    logic [TAG_W-1:0] w_req_tag;
    logic [IDX_W-1:0] w_req_idx;
    logic [OFS_W-1:0] w_req_word;
    logic [IDX_W-1:0] w_rd_idx;
    logic [OFS_W-1:0] w_rd_word;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    logic [31:0]      w_rd_data;
    logic             w_idle, w_lookup, w_hit, w_fill_beat, w_last;
    logic             w_unused;

    assign w_req_tag  = fetch_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_req_idx  = fetch_addr[2+OFS_W +: IDX_W];
    assign w_req_word = fetch_addr[2 +: OFS_W];
    assign w_unused   = ^fetch_addr[1:0];

    // Lookups in IDLE read at the live address; afterwards at the latched one.
    assign w_idle      = (r_state == ICACHE_IDLE);
    assign w_rd_idx    = w_idle ? w_req_idx  : r_idx;
    assign w_rd_word   = w_idle ? w_req_word : r_word;
    assign w_lookup    = w_idle && fetch_req && !flush;
    assign w_hit       = w_rd_valid && (w_rd_tag == w_req_tag);
    assign w_fill_beat = (r_state == ICACHE_FILL) && mem_valid;
    assign w_last      = (r_k == OFS_W'(LINE_WORDS - 1));

    icache_array #(
        .IDX_W (IDX_W),
        .OFS_W (OFS_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst_in       (rst_in),
        .rd_idx       (w_rd_idx),
        .rd_word      (w_rd_word),
        .rd_valid     (w_rd_valid),
        .rd_tag       (w_rd_tag),
        .rd_data      (w_rd_data),
        .we           (rdy_in && w_fill_beat),
        .wr_idx       (r_idx),
        .wr_word      (r_k),
        .wr_data      (mem_data),
        .wr_set_valid (w_last),
        .wr_tag       (r_tag)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ICACHE_IDLE:  if (w_lookup) w_state_nxt = w_hit ? ICACHE_RESP : ICACHE_FILL;
            ICACHE_RESP:  w_state_nxt = ICACHE_IDLE;
            ICACHE_FILL:  if (w_fill_beat && w_last)
                              w_state_nxt = (r_abort || flush) ? ICACHE_IDLE : ICACHE_DELIV;
            ICACHE_DELIV: w_state_nxt = flush ? ICACHE_IDLE : ICACHE_RESP;
            default:      w_state_nxt = ICACHE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state    <= ICACHE_IDLE;
            r_tag      <= '0;
            r_idx      <= '0;
            r_word     <= '0;
            r_k        <= '0;
            r_abort    <= 1'b0;
            r_inst_out <= '0;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
            if (w_lookup) begin
                r_tag  <= w_req_tag;
                r_idx  <= w_req_idx;
                r_word <= w_req_word;
                if (w_hit) r_inst_out <= w_rd_data;
            end
            // Counter wraps to zero after the last word, ready for the next fill.
            if (w_fill_beat) r_k <= r_k + OFS_W'(1);
            if (r_state == ICACHE_FILL) begin
                if (w_fill_beat && w_last) r_abort <= 1'b0;
                else if (flush)            r_abort <= 1'b1;
            end
            if (r_state == ICACHE_DELIV) r_inst_out <= w_rd_data;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (rdy_in && w_lookup) begin
            if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
            else       r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    assign inst_rdy = (r_state == ICACHE_RESP) && !flush;
    assign inst_out = r_inst_out;
    assign mem_req  = (r_state == ICACHE_FILL);
    assign mem_addr = {r_tag, r_idx, r_k, 2'b00};

endmodule

`default_nettype wire
